// File: rtl/spmv_pkg.sv
// Shared SpMV constants and the result-collector FSM state encoding.
package spmv_pkg;

    localparam int unsigned DEF_ROWS   = 1024;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/result_collector_if.sv
// Beat input / drained-row output bundle of the result collector.
interface result_collector_if
    import spmv_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_zeros;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_op1;
    logic [DATA_W-1:0] in_op2;
    logic              in_done;
    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              all_done;
    logic              err_late;

    modport master (
        output in_valid, in_zeros, in_addr, in_op1, in_op2, in_done, out_ready,
        input  out_valid, out_addr, out_data, busy, all_done, err_late
    );

    modport slave (
        input  in_valid, in_zeros, in_addr, in_op1, in_op2, in_done, out_ready,
        output out_valid, out_addr, out_data, busy, all_done, err_late
    );
endinterface

// File: rtl/res_rowmem.sv
// Row accumulator storage: combinational read (0 for unwritten rows), synchronous write,
// single-cycle clear of every written bit.
module res_rowmem #(
    parameter int unsigned ROWS   = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [ROWS];
    logic [ROWS-1:0]   written;

    always_ff @(posedge clk) begin
        if (clear) begin
            written <= '0;
        end else if (we) begin
            written[waddr] <= 1'b1;
        end
    end

    // Contents need no reset: the written bits mask stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = written[raddr] ? mem[raddr] : '0;
endmodule

// File: rtl/result_collector.sv
// Accumulates per-row partial sums from the multiplier, then drains every row in order.
// Define RESULT_SAT_EN for signed saturating accumulation instead of wrap-around.
module result_collector
    import spmv_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    result_collector_if.slave bus
);
    state_e            state;
    logic              s1_valid;
    logic              s1_zeros;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_op1;
    logic [DATA_W-1:0] s1_op2;

    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              all_done;
    logic              err_late;

    logic              in_range_c;
    logic              load_c;
    logic              transfer_c;
    logic [ADDR_W-1:0] drain_addr_c;
    logic [ADDR_W-1:0] raddr_c;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] acc_c;
    logic [DATA_W-1:0] wdata_c;

    assign in_range_c   = {1'b0, bus.in_addr} < (ADDR_W+1)'(ROWS);
    assign load_c       = bus.in_valid && in_range_c && (state == ACCUM || state == FLUSH);
    assign transfer_c   = out_valid && bus.out_ready;
    assign drain_addr_c = (state == DRAIN) ? ADDR_W'(out_addr + 1'b1) : '0;
    // The stage-2 write lands before the next beat reads, so back-to-back hits see the update.
    assign raddr_c      = s1_valid ? s1_addr : drain_addr_c;

`ifdef RESULT_SAT_EN
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
        if (a[DATA_W-1] == b[DATA_W-1] && s[DATA_W-1] != a[DATA_W-1]) begin
            s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return s;
    endfunction

    assign acc_c = sat_add(rdata, sat_add(s1_op1, s1_op2));
`else
    assign acc_c = rdata + s1_op1 + s1_op2;
`endif

    assign wdata_c = s1_zeros ? rdata : acc_c;

    res_rowmem #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rowmem (
        .clk   (clk),
        .clear (reset),
        .we    (s1_valid),
        .waddr (s1_addr),
        .wdata (wdata_c),
        .raddr (raddr_c),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (load_c) begin
            s1_zeros <= bus.in_zeros;
            s1_addr  <= bus.in_addr;
            s1_op1   <= bus.in_op1;
            s1_op2   <= bus.in_op2;
        end
    end

    // Control FSM with registered status and drain outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b1;
            all_done  <= 1'b0;
            err_late  <= 1'b0;
        end else begin
            s1_valid <= load_c;
            if (bus.in_valid && !load_c) begin
                err_late <= 1'b1;
            end
            case (state)
                ACCUM: begin
                    if (bus.in_done) begin
                        state <= FLUSH;
                        busy  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!s1_valid && !load_c) begin
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_addr  <= '0;
                        out_data  <= rdata;
                    end
                end
                DRAIN: begin
                    if (transfer_c) begin
                        if (out_addr == ADDR_W'(ROWS - 1)) begin
                            state     <= FIN;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            all_done  <= 1'b1;
                        end else begin
                            out_addr <= drain_addr_c;
                            out_data <= rdata;
                        end
                    end
                end
                FIN: begin
                    state <= FIN;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_data  = out_data;
    assign bus.busy      = busy;
    assign bus.all_done  = all_done;
    assign bus.err_late  = err_late;
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: row model, expected-drain queue, handshake stalls,
// late beats and reset abort.
module tb_result_collector;
    import spmv_pkg::*;

    localparam int unsigned ROWS   = DEF_ROWS;
    localparam int unsigned ADDR_W = DEF_ADDR_W;
    localparam int unsigned DATA_W = DEF_DATA_W;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    result_collector_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    result_collector #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_mem [ROWS];
    bit          exp_wr  [ROWS];
    exp_t        sb_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_add(input logic [63:0] a, input logic [63:0] b);
`ifdef RESULT_SAT_EN
        logic signed [64:0] t;
        t = 65'($signed(a)) + 65'($signed(b));
        if (t > 65'sh0_7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (t < -65'sh0_8000_0000_0000_0000) return 64'h8000_0000_0000_0000;
        return t[63:0];
`else
        return a + b;
`endif
    endfunction

    task automatic model_clear();
        for (int r = 0; r < int'(ROWS); r++) exp_wr[r] = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_addr",  64'(bus.out_addr),  64'd0);
        check("rst_out_data",  bus.out_data,       64'd0);
        check("rst_busy",      64'(bus.busy),      64'd1);
        check("rst_all_done",  64'(bus.all_done),  64'd0);
        check("rst_err_late",  64'(bus.err_late),  64'd0);
        reset = 1'b0;
        model_clear();
    endtask

    // One cycle of stimulus; optional in_done alongside the beat.
    task automatic beat(input int addr, input logic [63:0] op1, input logic [63:0] op2,
                        input bit zeros, input bit valid, input bit done);
        bus.in_valid = valid;
        bus.in_zeros = zeros;
        bus.in_addr  = ADDR_W'(addr);
        bus.in_op1   = op1;
        bus.in_op2   = op2;
        bus.in_done  = done;
        if (valid && addr < int'(ROWS)) begin
            if (zeros) begin
                if (!exp_wr[addr]) begin
                    exp_mem[addr] = 64'd0;
                    exp_wr[addr]  = 1'b1;
                end
            end else begin
                exp_mem[addr] = model_add(exp_wr[addr] ? exp_mem[addr] : 64'd0, model_add(op1, op2));
                exp_wr[addr]  = 1'b1;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_zeros = 1'b0;
        bus.in_done  = 1'b0;
    endtask

    task automatic drain(input int stall_addr, input int late_addr, input int abort_addr);
        int   n_xfer = 0;
        int   stall  = 0;
        int   budget = 0;
        int   late   = 0;
        bit   done   = 1'b0;
        exp_t e;
        for (int r = 0; r < int'(ROWS); r++) begin
            e.addr = r;
            e.data = exp_wr[r] ? exp_mem[r] : 64'd0;
            sb_q.push_back(e);
        end
        bus.out_ready = 1'b1;
        while (!done) begin
            bus.in_valid = 1'b0;
            if (budget++ > 4 * int'(ROWS)) begin
                check("drain_timeout", 64'(bus.all_done), 64'd1);
                done = 1'b1;
            end else if (bus.all_done) begin
                check("fin_out_valid", 64'(bus.out_valid), 64'd0);
                check("fin_busy",      64'(bus.busy),      64'd0);
                check("xfer_count",    64'(n_xfer),        64'(ROWS));
                done = 1'b1;
            end else if (bus.out_valid) begin
                if (late == 1) begin
                    check("err_late_set", 64'(bus.err_late), 64'd1);
                    late = 2;
                end
                if (abort_addr >= 0 && int'(bus.out_addr) == abort_addr) begin
                    bus.out_ready = 1'b0;
                    done = 1'b1;
                end else begin
                    if (stall_addr >= 0 && int'(bus.out_addr) == stall_addr && stall < 10) begin
                        bus.out_ready = 1'b0;
                        stall++;
                        check("stall_addr", 64'(bus.out_addr), 64'(stall_addr));
                        if (sb_q.size() > 0) check("stall_data", bus.out_data, sb_q[0].data);
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                    if (late_addr >= 0 && int'(bus.out_addr) == late_addr && late == 0) begin
                        bus.in_valid = 1'b1;
                        bus.in_addr  = ADDR_W'(60);
                        bus.in_op1   = 64'd11;
                        bus.in_op2   = 64'd22;
                        late = 1;
                    end
                    if (bus.out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("sb_empty", 64'(sb_q.size()), 64'd1);
                        end else begin
                            e = sb_q.pop_front();
                            check("row_addr", 64'(bus.out_addr), 64'(e.addr));
                            check("row_data", bus.out_data, e.data);
                        end
                        n_xfer++;
                    end
                end
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_zeros  = 1'b0;
        bus.in_addr   = '0;
        bus.in_op1    = '0;
        bus.in_op2    = '0;
        bus.in_done   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Single beat, separate in_done.
        beat(5, 64'd3, 64'd4, 1'b0, 1'b1, 1'b0);
        beat(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        drain(-1, -1, -1);
        check("a_err_late", 64'(bus.err_late), 64'd0);

        // Forwarding, zeros rows, overflow, random traffic, stall at row 3.
        do_reset();
        beat(9,   64'd1,  64'd2,  1'b0, 1'b1, 1'b0);
        beat(9,   64'd10, 64'd20, 1'b0, 1'b1, 1'b0);
        beat(0,   64'd0,  64'd0,  1'b1, 1'b1, 1'b0);
        beat(0,   64'd5,  64'd0,  1'b0, 1'b1, 1'b0);
        beat(12,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
        beat(12,  64'd0,  64'd0,  1'b1, 1'b1, 1'b0);
        beat(700, 64'd0,  64'd0,  1'b1, 1'b1, 1'b0);
        beat(3,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            beat(int'($urandom_range(0, 31)), 64'($urandom), 64'($urandom),
                 ($urandom_range(0, 7) == 0), 1'b1, 1'b0);
        end
        beat(ROWS - 1, 64'd100, 64'd23, 1'b0, 1'b1, 1'b1);
        drain(3, -1, -1);
        check("b_err_late", 64'(bus.err_late), 64'd0);

        // Late beat during drain, then reset mid-drain.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            beat(40 + 3 * i, 64'($urandom), 64'($urandom), 1'b0, 1'b1, 1'b0);
        end
        beat(60, 64'd7, 64'd8, 1'b0, 1'b1, 1'b1);
        drain(-1, 50, 100);
        check("c_abort_addr", 64'(bus.out_addr), 64'd100);
        do_reset();
        check("c_post_busy",  64'(bus.busy),      64'd1);
        check("c_post_valid", 64'(bus.out_valid), 64'd0);
        beat(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("c_still_accum", 64'(bus.busy), 64'd1);
        beat(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        drain(-1, -1, -1);
        check("c_err_late", 64'(bus.err_late), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter ROWS, default 1024: number of result rows buffered; out_addr runs 0..ROWS-1.
REQ-002 Parameter ADDR_W, default 10: row address width; ROWS SHALL be <= 2**ADDR_W.
REQ-003 Parameter DATA_W, default 64: partial-sum and result width.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  one result beat from the multiplier stage this cycle.
REQ-007 in_zeros  in  1  qualifies in_valid: the row has no nonzeros, so its contribution is 0.
REQ-008 in_addr  in  ADDR_W  row index of the beat.
REQ-009 in_op1 / in_op2  in  DATA_W each  two lane partial sums for in_addr.
REQ-010 in_done  in  1  level; multiplier has issued its last beat.
REQ-011 out_ready  in  1  downstream accepts out_data.
REQ-012 out_valid  out  1  out_addr/out_data hold a valid drained row.
REQ-013 out_addr  out  ADDR_W  row index being drained.
REQ-014 out_data  out  DATA_W  accumulated row result.
REQ-015 busy  out  1  high in ACCUM and DRAIN.
REQ-016 all_done  out  1  high in FIN.
REQ-017 err_late  out  1  sticky; an in_valid beat arrived in DRAIN or FIN.

Function
REQ-018 FSM states ACCUM, FLUSH, DRAIN and FIN; reset enters ACCUM.
REQ-019 Stage 1 registers each beat; stage 2 reads row[in_addr], adds op1+op2 (0 if in_zeros), and writes back; memory reflects a beat 2 cycles after it is presented.
REQ-020 Row read in stage 2 SHALL return 0 if the row's written bit is clear; the write sets the bit.
REQ-021 Back-to-back beats to the same row SHALL both accumulate: the stage-2 result is forwarded, with no lost update.
REQ-022 in_zeros with a clear written bit stores 0 and sets the bit; on a written row it adds nothing.
REQ-023 Addition wraps modulo 2**DATA_W by default.
REQ-024 in_addr >= ROWS: the beat is dropped and err_late is set.
REQ-025 in_done in ACCUM moves to FLUSH; a beat presented in the same cycle is still accumulated.
REQ-026 FLUSH waits until stage 1 and stage 2 are empty (at most 2 cycles), then goes to DRAIN with out_addr = 0.
REQ-027 In DRAIN, out_valid = 1, out_data = row[out_addr] (0 if unwritten), registered.
REQ-028 DRAIN handshake: out_addr advances only on out_valid & out_ready; out_data is stable while out_ready is low.
REQ-029 The transfer at out_addr = ROWS-1 moves the FSM to FIN; out_valid drops the next cycle.
REQ-030 FIN holds; all_done = 1; inputs are ignored until reset.
REQ-031 in_valid in DRAIN or FIN is ignored, and err_late is set.

Reset
REQ-032 reset clears all written bits, pipeline valids, out_addr, err_late and the FSM (to ACCUM) in one cycle; row data contents are don't-care.
REQ-033 Reset values: out_valid = 0, out_addr = 0, out_data = 0, busy = 1, all_done = 0, err_late = 0.
REQ-034 Reset mid-DRAIN SHALL abort the drain; the next cycle is ACCUM with an empty buffer.

Configuration
REQ-035 Macro RESULT_SAT_EN defined: accumulation is signed two's-complement saturating, clamping to 2**(DATA_W-1)-1 or -2**(DATA_W-1).
REQ-036 Macro RESULT_SAT_EN undefined: accumulation wraps (REQ-023); there is no saturation logic.

Structure
REQ-037 Shared package spmv_pkg holds ADDR_W, DATA_W, ROWS defaults and the FSM state enum (ACCUM, FLUSH, DRAIN, FIN).
REQ-038 One sub-module, res_rowmem: ROWS x DATA_W array plus written-bit vector, combinational read, synchronous write, single-cycle bit clear.

Verification
REQ-039 Beat addr 5, op1=3, op2=4, then in_done -> DRAIN yields row 5 = 7 and every other row = 0, then all_done.
REQ-040 Consecutive beats addr 9: (1,2) then (10,20) -> row 9 = 33 (forwarding check).
REQ-041 in_zeros beat addr 0, then beat addr 0 (5,0) -> row 0 = 5.
REQ-042 out_ready held low 10 cycles at out_addr 3 -> out_addr/out_data stable; ROWS transfers total before FIN.
REQ-043 op1 = 2**63-1, op2 = 1 -> wrap gives -2**63; with RESULT_SAT_EN gives 2**63-1.
REQ-044 Beat in DRAIN -> err_late = 1 and data unchanged; reset at out_addr 100 -> ACCUM, then all rows drain as 0.
